// File: rtl/ah_snoop_dedup_push_pkg.sv
//------------------------------------------------------------------------------
// Module   : ah_snoop_pkg
// Purpose  : Shared widths, tag type and FSM state encoding for the
//            snoopable-FIFO write-side front end (ah_snoop_dedup_push).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ah_snoop_pkg;

  localparam int AH_DATA_W = 32;
  localparam int AH_TAG_W  = 22;

  typedef logic [AH_TAG_W-1:0] tag_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNOOP = 3'd1,
    ST_HOLD  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  // Snoop tag carried in the low bits of a request payload.
  function automatic tag_t tag_of(input logic [AH_DATA_W-1:0] data);
    return data[AH_TAG_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ah_snoop_dedup_push_if.sv
//------------------------------------------------------------------------------
// Module   : ah_snoop_dedup_push_if
// Purpose  : Bundles the upstream request handshake, the FIFO snoop compare
//            and the FIFO push handshake of ah_snoop_dedup_push.
//            slave  = the dedup front end
//            master = its environment (upstream source + FIFO)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ah_snoop_dedup_push_if
  import ah_snoop_pkg::*;
#(
  parameter int DATA_W = AH_DATA_W,
  parameter int TAG_W  = AH_TAG_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              dup_mode;
  logic [TAG_W-1:0]  snoop_data;
  logic              snoop_match;
  logic              fifo_wr_valid;
  logic              fifo_wr_ready;
  logic [DATA_W-1:0] fifo_wr_data;

  modport slave (
    input  in_valid, in_data, dup_mode, snoop_match, fifo_wr_ready,
    output in_ready, snoop_data, fifo_wr_valid, fifo_wr_data
  );

  modport master (
    output in_valid, in_data, dup_mode, snoop_match, fifo_wr_ready,
    input  in_ready, snoop_data, fifo_wr_valid, fifo_wr_data
  );

endinterface

`default_nettype wire

// File: rtl/ah_snoop_dedup_push_sat_counter.sv
//------------------------------------------------------------------------------
// Module   : ah_sat_counter
// Purpose  : CNT_W-bit up counter with synchronous clear that sticks at its
//            all-ones value instead of wrapping. Only built when
//            AH_SNOOP_DROP_CNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifdef AH_SNOOP_DROP_CNT_EN
module ah_sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr_i,
  input  wire logic             inc_i,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increment only while below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

`default_nettype wire

// File: rtl/ah_snoop_dedup_push.sv
//------------------------------------------------------------------------------
// Module   : ah_snoop_dedup_push
// Purpose  : Write-side front end of the snoopable FIFO. Captures one upstream
//            request, snoops the FIFO with its tag, then pushes it, drops it
//            (dup_mode=0) or holds it until the tag is gone (dup_mode=1).
//            A one-entry last-pushed-tag guard covers the cycle in which a
//            freshly pushed entry is not yet visible to the FIFO comparator.
// Options  : AH_SNOOP_DROP_CNT_EN - enables the saturating drop counter;
//            without it drop_cnt is tied to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ah_snoop_dedup_push
  import ah_snoop_pkg::*;
#(
  parameter int DATA_W = AH_DATA_W,
  parameter int TAG_W  = AH_TAG_W,
  parameter int CNT_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  ah_snoop_dedup_push_if.slave   bus,
  output logic                   drop_pulse,
  output logic [CNT_W-1:0]       drop_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] req_q, req_d;
  logic              mode_q, mode_d;
  logic [TAG_W-1:0]  last_tag_q, last_tag_d;
  logic              last_vld_q, last_vld_d;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              in_ready;
  logic [TAG_W-1:0]  snoop_data;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              drop;

  assign req_tag = req_q[TAG_W-1:0];

  // Duplicate if the FIFO reports it or it equals the entry just pushed.
  assign hit = bus.snoop_match | (last_vld_q & (last_tag_q == req_tag));

  // Next-state and output decode; every target defaults first.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mode_d     = mode_q;
    last_tag_d = last_tag_q;
    // The guard lives for one IDLE cycle; it is carried into SNOOP only
    // when a request is captured in that very cycle.
    last_vld_d = 1'b0;
    in_ready   = 1'b0;
    snoop_data = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    drop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          req_d      = bus.in_data;
          mode_d     = bus.dup_mode;
          last_vld_d = last_vld_q;
          state_d    = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        snoop_data = req_tag;
        if (!hit) begin
          state_d = ST_PUSH;
        end else if (!mode_q) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        snoop_data = req_tag;
        if (!hit) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        wr_valid = 1'b1;
        wr_data  = req_q;
        if (bus.fifo_wr_ready) begin
          last_tag_d = req_tag;
          last_vld_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DROP: begin
        drop    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured request and last-pushed-tag guard registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      mode_q     <= 1'b0;
      last_tag_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      mode_q     <= mode_d;
      last_tag_q <= last_tag_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.snoop_data    = snoop_data;
  assign bus.fifo_wr_valid = wr_valid;
  assign bus.fifo_wr_data  = wr_data;
  assign drop_pulse        = drop;

`ifdef AH_SNOOP_DROP_CNT_EN
  ah_sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rstn),
    .clr_i (1'b0),
    .inc_i (drop),
    .cnt_o (drop_cnt)
  );
`else
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ah_snoop_dedup_push.sv
//------------------------------------------------------------------------------
// Module   : tb_ah_snoop_dedup_push
// Purpose  : Self-checking bench for ah_snoop_dedup_push: directed scenarios
//            with literal expectations, a drop-counter saturation burst and a
//            randomized phase, all checked every cycle against a
//            transaction-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ah_snoop_dedup_push;
  import ah_snoop_pkg::*;

  localparam int DW = 32;
  localparam int TW = 22;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef AH_SNOOP_DROP_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          drop_pulse;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  ah_snoop_dedup_push_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  ah_snoop_dedup_push #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One request is outstanding at a time. Its life: captured, looked up
  // (repeatedly while held), then either pushed (waiting for FIFO ready) or
  // dropped for one cycle. The guard applies only to the first lookup of a
  // request captured the cycle right after a push handshake.
  bit            chk_en;
  bit            m_busy, m_push, m_drop, m_mode, m_look, m_hit;
  logic [DW-1:0] m_req;
  logic [TW-1:0] m_tag, push_tag;
  int            cyc = 0, cap_cyc = -100, push_cyc = -100, m_cnt = 0;

  always @(negedge clk) begin
    if (rstn) begin
      m_busy = 0; m_push = 0; m_drop = 0; m_cnt = 0;
      cap_cyc = -100; push_cyc = -100;
      if (chk_en) begin
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_wr_valid", bus.fifo_wr_valid, 0);
        chk("rst_wr_data", bus.fifo_wr_data, 0);
        chk("rst_snoop", bus.snoop_data, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_cnt", drop_cnt, 0);
      end
    end else begin
      m_tag  = m_req[TW-1:0];
      m_look = m_busy && !m_push && !m_drop;
      m_hit  = bus.snoop_match ||
               ((cyc == cap_cyc + 1) && (cap_cyc == push_cyc + 1) && (m_tag == push_tag));
      if (chk_en) begin
        chk("in_ready", bus.in_ready, !m_busy);
        chk("wr_valid", bus.fifo_wr_valid, m_push);
        if (m_push) chk("wr_data", bus.fifo_wr_data, m_req);
        if (m_look) chk("snoop_data", bus.snoop_data, m_tag);
        chk("drop_pulse", drop_pulse, m_drop);
        chk("drop_cnt", drop_cnt, m_cnt);
      end
      if (m_drop) begin
        m_drop = 0; m_busy = 0;
        if (CNT_ON != 0 && m_cnt < CNT_MAX) m_cnt++;
      end else if (m_push) begin
        if (bus.fifo_wr_ready) begin
          m_push = 0; m_busy = 0; push_cyc = cyc; push_tag = m_tag;
        end
      end else if (m_busy) begin
        if (!m_hit) m_push = 1;
        else if (!m_mode) m_drop = 1;
      end else if (bus.in_valid) begin
        m_busy = 1; m_req = bus.in_data; m_mode = bus.dup_mode; cap_cyc = cyc;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit m, input bit sm, input bit wr);
    bus.in_valid      = v;
    bus.in_data       = d;
    bus.dup_mode      = m;
    bus.snoop_match   = sm;
    bus.fifo_wr_ready = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] rnd_d;
  logic [TW-1:0] tags [4];

  initial begin
    tags[0] = 22'h000001; tags[1] = 22'h3FFFFF; tags[2] = 22'h123456; tags[3] = 22'h0ABCDE;
    chk_en = 1;
    rstn = 1'b1;

    // 1: reset held with a valid request present
    drive(1, 32'hDEAD_BEEF, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t1_no_push", bus.fifo_wr_valid, 0);
      chk("t1_cnt", drop_cnt, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    rstn = 1'b0;
    @(negedge clk); chk("t1_ready_after", bus.in_ready, 1);
    tick();

    // 2: plain push, valid two cycles after accept
    drive(1, 32'h0000_0005, 0, 0, 1);
    @(negedge clk); chk("t2_accept", bus.in_ready, 1);
    tick(); drive(0, 0, 0, 0, 1);
    @(negedge clk); chk("t2_snoop", bus.snoop_data, 32'h5); chk("t2_early", bus.fifo_wr_valid, 0);
    tick();
    @(negedge clk); chk("t2_valid", bus.fifo_wr_valid, 1); chk("t2_data", bus.fifo_wr_data, 32'h5);
    tick(); tick();

    // 3: duplicate dropped
    drive(1, 32'h0012_3456, 0, 1, 1);
    tick(); drive(0, 0, 0, 1, 1);
    @(negedge clk); chk("t3_snoop", bus.snoop_data, 32'h123456);
    tick();
    @(negedge clk); chk("t3_drop", drop_pulse, 1); chk("t3_nopush", bus.fifo_wr_valid, 0);
    tick(); drive(0, 0, 0, 0, 1);
    @(negedge clk); chk("t3_cnt", drop_cnt, CNT_ON); chk("t3_pulse_end", drop_pulse, 0);
    tick();

    // 4: duplicate held while match persists
    drive(1, 32'hABCD_1234, 1, 1, 1);
    tick(); drive(0, 0, 0, 1, 1);
    @(negedge clk); chk("t4_snoop_rdy", bus.in_ready, 0);
    tick();
    repeat (3) begin
      @(negedge clk); chk("t4_hold_rdy", bus.in_ready, 0); chk("t4_hold_nopush", bus.fifo_wr_valid, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clk); chk("t4_release_rdy", bus.in_ready, 0); chk("t4_release_nopush", bus.fifo_wr_valid, 0);
    tick();
    @(negedge clk); chk("t4_valid", bus.fifo_wr_valid, 1); chk("t4_data", bus.fifo_wr_data, 32'hABCD_1234);
    tick(); tick();

    // 5: FIFO full stalls the push and backpressures upstream
    drive(1, 32'h0000_7777, 0, 0, 0);
    tick(); drive(1, 32'h0000_8888, 0, 0, 0);
    tick();
    repeat (10) begin
      @(negedge clk);
      chk("t5_valid", bus.fifo_wr_valid, 1);
      chk("t5_data", bus.fifo_wr_data, 32'h7777);
      chk("t5_bp", bus.in_ready, 0);
      tick();
    end
    drive(1, 32'h0000_8888, 0, 0, 1);
    @(negedge clk); chk("t5_hs_valid", bus.fifo_wr_valid, 1);
    tick();
    @(negedge clk); chk("t5_second_accept", bus.in_ready, 1);
    tick(); drive(0, 0, 0, 0, 1);
    tick();
    @(negedge clk); chk("t5_second_data", bus.fifo_wr_data, 32'h8888);
    tick(); tick();

    // 6: back-to-back same tag caught by the last-tag guard
    drive(1, 32'h003F_FFFF, 0, 0, 1);
    tick(); tick(); tick();
    @(negedge clk); chk("t6_reaccept", bus.in_ready, 1);
    tick(); drive(0, 0, 0, 0, 1);
    @(negedge clk); chk("t6_snoop", bus.snoop_data, 32'h3FFFFF); chk("t6_nopush", bus.fifo_wr_valid, 0);
    tick();
    @(negedge clk); chk("t6_drop", drop_pulse, 1); chk("t6_nopush2", bus.fifo_wr_valid, 0);
    tick(); tick();

    // drop-counter saturation: 300 drops at 3 cycles each
    drive(1, 32'h0000_0001, 0, 1, 1);
    repeat (900) tick();
    drive(0, 0, 0, 0, 1);
    tick(); tick();
    @(negedge clk); chk("sat_cnt", drop_cnt, CNT_ON * CNT_MAX);
    tick();

    // randomized traffic with occasional mid-flight reset
    for (int i = 0; i < 3000; i++) begin
      rnd_d = $urandom;
      rnd_d[TW-1:0] = tags[$urandom_range(0, 3)];
      drive($urandom_range(0, 9) < 6, rnd_d, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
      rstn = ($urandom_range(0, 499) == 0);
      tick();
    end
    rstn = 1'b0;
    drive(0, 0, 0, 0, 1);
    repeat (5) tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
